cache_ctrl_nway: RTL and testbench
==================================

Name: cache_ctrl_nway

Overview:
- Parametrised write-back, write-allocate controller for an N-way set-associative cache with multi-word lines over a pipelined banked memory.
- Sits between the CPU memory stage and the cache data/tag arrays plus the banked main memory.
- Adds over the previous controller: configurable way count and line length, victim selection, and a response-tracked fill that overlaps memory latency with cache writes.
- The refill pass reuses the hit path, so a write miss merges through a retry compare.

Parameters:
WAYS, 2, number of ways; power of two, 1..8
WORDS, 4, 16-bit words per line; power of two, 2..8
WSEL_W, $clog2(WORDS), word-select width (derived localparam)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
rd  in  1  CPU read request
wr  in  1  CPU write request
offset_in  in  WSEL_W+1  CPU byte offset; bit 0 must be 0
hit  in  WAYS  per-way tag match from arrays (valid only while comp=1)
valid  in  WAYS  per-way valid bit of indexed set
dirty  in  WAYS  per-way dirty bit of indexed set
stall_mem  in  1  memory cannot accept a request this cycle
mem_rvalid  in  1  read data returning from memory (in issue order)
way_en  out  WAYS  one-hot way select to the arrays
enable  out  1  array enable
comp  out  1  compare mode
wr_cache  out  1  array write strobe
valid_in  out  1  valid bit written when comp=0
word_sel  out  WSEL_W  word index to the arrays
word_sel_src  out  1  1 = word_sel from FSM, 0 = from offset_in
data_in_sel  out  1  1 = array data from memory, 0 = from CPU
tag_sel  out  1  1 = memory address tag from victim tag_out, 0 = from CPU
rd_mem  out  1  memory read request
wr_mem  out  1  memory write request
mem_word  out  WSEL_W  word index of the memory request
stall_outside  out  1  CPU stall
done  out  1  one-cycle completion pulse
cache_hit  out  1  asserted with done when serviced without a miss
err  out  1  one-cycle error pulse

Behaviour:
- Reset (sync): state IDLE, all counters 0, rr_ptr 0, every output 0 except enable=1; a reset mid-operation abandons any writeback or fill with no further memory requests.
- States: IDLE, COMP, WB, FILL, RETRY, DONE, ERR.
- IDLE:
  - rd&wr -> ERR; offset_in[0]=1 with rd|wr -> ERR.
  - rd^wr -> COMP; stall_outside = rd|wr.
- COMP:
  - comp=1, enable=1, wr_cache=wr, word_sel_src=0.
  - hv = hit & valid.
  - |hv -> DONE with cache_hit=1 and way_en=hv.
  - Else select the victim: lowest-index invalid way; if none, rr_ptr. Latch it in victim_reg.
  - Victim dirty -> WB, otherwise -> FILL.
  - rr_ptr increments (mod WAYS) only when a valid way is evicted.
- WB:
  - wr_mem=1, tag_sel=1, word_sel_src=1, way_en=victim_reg, word_sel=mem_word=wb_cnt.
  - wb_cnt advances when stall_mem=0; after word WORDS-1 is accepted -> FILL.
- FILL, issue side:
  - rd_mem=1 while iss_cnt<WORDS; iss_cnt advances when stall_mem=0.
  - mem_word = iss_cnt; tag_sel=0.
- FILL, response side:
  - On mem_rvalid: wr_cache=1, comp=0, valid_in=1, data_in_sel=1, word_sel_src=1, word_sel=rsp_cnt, way_en=victim_reg; rsp_cnt increments.
  - Issue and response may occur in the same cycle.
  - mem_rvalid with rsp_cnt==iss_cnt, i.e. no outstanding request -> ERR.
  - After response WORDS-1 is written -> RETRY.
- RETRY: identical to COMP, but must hit. Hit -> DONE with cache_hit=0 (a write here sets dirty via comp=1). Miss -> ERR.
- DONE:
  - done=1, stall_outside=0.
  - rd^wr -> COMP; rd&wr -> ERR; otherwise -> IDLE.
- ERR: err=1 for one cycle, all counters cleared -> IDLE.
- Counters are WSEL_W+1 bits wide so that WORDS is representable; no wrap-around inside a transaction.

Decomposition:
- Shared package cache_pkg: state enum and WORDS/WAYS limit constants.
- Sub-module cache_victim_sel (combinational priority encoder over ~valid, with the rr_ptr register inside).

Test Plan:
- Read hit in way 1 (hit=2'b10, valid=2'b11): rd pulse -> DONE two cycles later, cache_hit=1, way_en=2'b10, no rd_mem.
- Read miss, way 0 invalid -> FILL with way_en=2'b01; 4 rd_mem issued with mem_word 0,1,2,3; 4 cache writes with valid_in=1; RETRY; done with cache_hit=0.
- Write miss, both ways valid, victim dirty, rr_ptr=1 -> 4 wr_mem with tag_sel=1 to way 1, then fill, then RETRY write sets dirty; rr_ptr becomes 0.
- stall_mem high 3 cycles during WB word 2 -> mem_word holds at 2, wb_cnt frozen, total WB length 7 cycles.
- mem_rvalid 2 cycles after each issue (latency overlap) -> rsp_cnt trails iss_cnt by 2; RETRY is entered exactly one cycle after the 4th response.
- Error cases: rd&wr=1 -> err pulse, then IDLE. offset_in=3'b011 -> err. rst asserted during FILL -> next cycle rd_mem=0 and the FSM is in IDLE.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encoding, parameter limits and helpers for cache_ctrl_nway
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COMP  = 3'd1,
    S_WB    = 3'd2,
    S_FILL  = 3'd3,
    S_RETRY = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam int MAX_WAYS  = 8;
  localparam int MAX_WORDS = 8;
  localparam int MIN_WORDS = 2;

  // A single-way cache still needs a 1-bit pointer register to stay legal.
  function automatic int way_idx_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// rtl/cache_victim_sel.sv - victim choice: lowest-index invalid way, else the round-robin pointer
module cache_victim_sel
  import cache_pkg::*;
#(
  parameter int WAYS = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [WAYS-1:0] i_valid,
  input  logic            i_evict_valid,
  output logic [WAYS-1:0] o_victim,
  output logic            o_all_valid
);

  localparam int PTR_W = way_idx_w(WAYS);

  logic [PTR_W-1:0] r_rr_ptr;
  logic [WAYS-1:0]  w_inv;
  logic [WAYS-1:0]  w_lowest_inv;

  // x & -x isolates the lowest set bit, giving the priority encode in one step.
  assign w_inv        = ~i_valid;
  assign w_lowest_inv = w_inv & (~w_inv + WAYS'(1));
  assign o_all_valid  = ~|w_inv;
  assign o_victim     = o_all_valid ? (WAYS'(1) << r_rr_ptr) : w_lowest_inv;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr <= '0;
    end else if (i_evict_valid) begin
      r_rr_ptr <= (WAYS == 1) ? '0 : r_rr_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/cache_ctrl_nway.sv
// rtl/cache_ctrl_nway.sv - write-back, write-allocate N-way cache controller with overlapped line fill
module cache_ctrl_nway
  import cache_pkg::*;
#(
  parameter  int WAYS   = 2,
  parameter  int WORDS  = 4,
  localparam int WSEL_W = $clog2(WORDS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd,
  input  logic              i_wr,
  input  logic [WSEL_W:0]   i_offset_in,
  input  logic [WAYS-1:0]   i_hit,
  input  logic [WAYS-1:0]   i_valid,
  input  logic [WAYS-1:0]   i_dirty,
  input  logic              i_stall_mem,
  input  logic              i_mem_rvalid,
  output logic [WAYS-1:0]   o_way_en,
  output logic              o_enable,
  output logic              o_comp,
  output logic              o_wr_cache,
  output logic              o_valid_in,
  output logic [WSEL_W-1:0] o_word_sel,
  output logic              o_word_sel_src,
  output logic              o_data_in_sel,
  output logic              o_tag_sel,
  output logic              o_rd_mem,
  output logic              o_wr_mem,
  output logic [WSEL_W-1:0] o_mem_word,
  output logic              o_stall_outside,
  output logic              o_done,
  output logic              o_cache_hit,
  output logic              o_err
);

  localparam int                CNT_W     = WSEL_W + 1;
  localparam logic [CNT_W-1:0]  N_WORDS   = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS - 1);

  if (WAYS < 1 || WAYS > MAX_WAYS || (WAYS & (WAYS - 1)) != 0 ||
      WORDS < MIN_WORDS || WORDS > MAX_WORDS || (WORDS & (WORDS - 1)) != 0) begin : g_param_check
    $error("cache_ctrl_nway: unsupported WAYS/WORDS");
  end

  state_t           r_state;
  logic [CNT_W-1:0] r_wb_cnt;
  logic [CNT_W-1:0] r_iss_cnt;
  logic [CNT_W-1:0] r_rsp_cnt;
  logic [WAYS-1:0]  r_victim;
  logic             r_hit;

  logic [WAYS-1:0]  w_hv;
  logic [WAYS-1:0]  w_victim;
  logic             w_hv_any;
  logic             w_all_valid;
  logic             w_victim_dirty;
  logic             w_evict_valid;
  logic             w_one_op;
  logic             w_bad_req;
  logic             w_iss_pending;
  logic             w_issue;
  logic             w_orphan_rsp;
  logic             w_fill_wr;

  assign w_hv           = i_hit & i_valid;
  assign w_hv_any       = |w_hv;
  assign w_victim_dirty = |(w_victim & i_valid & i_dirty);
  assign w_evict_valid  = (r_state == S_COMP) && !w_hv_any && w_all_valid;
  assign w_one_op       = i_rd ^ i_wr;
  assign w_bad_req      = (i_rd & i_wr) | ((i_rd | i_wr) & i_offset_in[0]);
  assign w_iss_pending  = (r_iss_cnt < N_WORDS);
  assign w_issue        = (r_state == S_FILL) && w_iss_pending && !i_stall_mem;
  // A response with nothing outstanding means the memory side lost sync with us.
  assign w_orphan_rsp   = i_mem_rvalid && (r_rsp_cnt == r_iss_cnt);
  assign w_fill_wr      = (r_state == S_FILL) && i_mem_rvalid && !w_orphan_rsp;

  cache_victim_sel #(
    .WAYS (WAYS)
  ) u_victim_sel (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_valid       (i_valid),
    .i_evict_valid (w_evict_valid),
    .o_victim      (w_victim),
    .o_all_valid   (w_all_valid)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_wb_cnt  <= '0;
      r_iss_cnt <= '0;
      r_rsp_cnt <= '0;
      r_victim  <= '0;
      r_hit     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wb_cnt  <= '0;
          r_iss_cnt <= '0;
          r_rsp_cnt <= '0;
          if (w_bad_req) r_state <= S_ERR;
          else if (w_one_op) r_state <= S_COMP;
        end
        S_COMP: begin
          r_hit <= w_hv_any;
          if (w_hv_any) begin
            r_state <= S_DONE;
          end else begin
            r_victim <= w_victim;
            r_state  <= w_victim_dirty ? S_WB : S_FILL;
          end
        end
        S_WB: begin
          if (!i_stall_mem) begin
            r_wb_cnt <= r_wb_cnt + 1'b1;
            if (r_wb_cnt == LAST_WORD) r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (w_issue) r_iss_cnt <= r_iss_cnt + 1'b1;
          if (w_orphan_rsp) begin
            r_state <= S_ERR;
          end else if (i_mem_rvalid) begin
            r_rsp_cnt <= r_rsp_cnt + 1'b1;
            if (r_rsp_cnt == LAST_WORD) r_state <= S_RETRY;
          end
        end
        S_RETRY: r_state <= w_hv_any ? S_DONE : S_ERR;
        S_DONE: begin
          r_wb_cnt  <= '0;
          r_iss_cnt <= '0;
          r_rsp_cnt <= '0;
          if (i_rd & i_wr) r_state <= S_ERR;
          else if (w_one_op) r_state <= S_COMP;
          else r_state <= S_IDLE;
        end
        S_ERR: begin
          r_wb_cnt  <= '0;
          r_iss_cnt <= '0;
          r_rsp_cnt <= '0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_way_en        = '0;
    o_enable        = 1'b1;
    o_comp          = 1'b0;
    o_wr_cache      = 1'b0;
    o_valid_in      = 1'b0;
    o_word_sel      = '0;
    o_word_sel_src  = 1'b0;
    o_data_in_sel   = 1'b0;
    o_tag_sel       = 1'b0;
    o_rd_mem        = 1'b0;
    o_wr_mem        = 1'b0;
    o_mem_word      = '0;
    o_stall_outside = 1'b0;
    o_done          = 1'b0;
    o_cache_hit     = 1'b0;
    o_err           = 1'b0;
    case (r_state)
      S_IDLE: o_stall_outside = i_rd | i_wr;
      // The refill retry is the hit path again, so a write miss merges here.
      S_COMP, S_RETRY: begin
        o_comp          = 1'b1;
        o_wr_cache      = i_wr;
        o_way_en        = w_hv;
        o_word_sel      = i_offset_in[WSEL_W:1];
        o_stall_outside = 1'b1;
      end
      S_WB: begin
        o_wr_mem        = 1'b1;
        o_tag_sel       = 1'b1;
        o_word_sel_src  = 1'b1;
        o_way_en        = r_victim;
        o_word_sel      = r_wb_cnt[WSEL_W-1:0];
        o_mem_word      = r_wb_cnt[WSEL_W-1:0];
        o_stall_outside = 1'b1;
      end
      S_FILL: begin
        o_rd_mem        = w_iss_pending;
        o_mem_word      = r_iss_cnt[WSEL_W-1:0];
        o_way_en        = r_victim;
        o_stall_outside = 1'b1;
        if (w_fill_wr) begin
          o_wr_cache     = 1'b1;
          o_valid_in     = 1'b1;
          o_data_in_sel  = 1'b1;
          o_word_sel_src = 1'b1;
          o_word_sel     = r_rsp_cnt[WSEL_W-1:0];
        end
      end
      S_DONE: begin
        o_done      = 1'b1;
        o_cache_hit = r_hit;
      end
      S_ERR: o_err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// tb/tb_cache_ctrl_nway.sv - randomized self-checking bench for cache_ctrl_nway against a transaction-level model
module tb_cache_ctrl_nway;

  localparam int WAYS   = 2;
  localparam int WORDS  = 4;
  localparam int WSEL_W = $clog2(WORDS);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, rd, wr, stall_mem, mem_rvalid;
  logic [WSEL_W:0]   offset_in;
  logic [WAYS-1:0]   hit, valid, dirty, way_en;
  logic              enable, comp, wr_cache, valid_in, word_sel_src, data_in_sel, tag_sel;
  logic              rd_mem, wr_mem, stall_outside, done, cache_hit, err;
  logic [WSEL_W-1:0] word_sel, mem_word;

  cache_ctrl_nway #(.WAYS(WAYS), .WORDS(WORDS)) dut (
    .i_clk(clk), .i_rst(rst), .i_rd(rd), .i_wr(wr), .i_offset_in(offset_in),
    .i_hit(hit), .i_valid(valid), .i_dirty(dirty), .i_stall_mem(stall_mem),
    .i_mem_rvalid(mem_rvalid), .o_way_en(way_en), .o_enable(enable), .o_comp(comp),
    .o_wr_cache(wr_cache), .o_valid_in(valid_in), .o_word_sel(word_sel),
    .o_word_sel_src(word_sel_src), .o_data_in_sel(data_in_sel), .o_tag_sel(tag_sel),
    .o_rd_mem(rd_mem), .o_wr_mem(wr_mem), .o_mem_word(mem_word),
    .o_stall_outside(stall_outside), .o_done(done), .o_cache_hit(cache_hit), .o_err(err)
  );

  // Model of the indexed set: the bench plays the tag/valid/dirty arrays.
  bit m_valid [WAYS];
  bit m_dirty [WAYS];
  int m_tag   [WAYS];
  int cur_tag;
  int m_rr;
  int n_chk  = 0;
  int n_pass = 0;
  int iw;
  bit seen;

  always_comb begin
    hit   = '0;
    valid = '0;
    dirty = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit[w]   = (m_tag[w] == cur_tag);
      valid[w] = m_valid[w];
      dirty[w] = m_dirty[w];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [31:0] idle_vec();
    return {way_en, comp, wr_cache, valid_in, word_sel, word_sel_src, data_in_sel, tag_sel,
            rd_mem, wr_mem, mem_word, stall_outside, done, cache_hit, err};
  endfunction

  // smode 0: random memory stalls; 1: stall 3 cycles on writeback word 2 only.
  // lmode 0: random in-order read latency 1..4; 1: fixed latency 2.
  task automatic txn(input bit is_wr, input int tag, input int smode, input int lmode);
    int hw, vic, wb_n, iss_n, fill_n, wb_cyc, stall_left, last_fill, ncomp, ret;
    bit all_v, exp_wb, fin, switched, saw_err;
    int rq[$];
    hw = -1;
    vic = -1;
    for (int w = 0; w < WAYS; w++) if (m_valid[w] && m_tag[w] == tag) hw = w;
    for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[w]) vic = w;
    all_v = (vic < 0);
    if (all_v) vic = m_rr;
    exp_wb = (hw < 0) && m_valid[vic] && m_dirty[vic];
    wb_n = 0; iss_n = 0; fill_n = 0; wb_cyc = 0; stall_left = 3; last_fill = -10; ncomp = 0;
    fin = 0; switched = 0; saw_err = 0;
    @(negedge clk);
    cur_tag   = tag;
    rd        = !is_wr;
    wr        = is_wr;
    offset_in = (WSEL_W + 1)'(2 * $urandom_range(0, WORDS - 1));
    for (int c = 0; c < 300 && !fin; c++) begin
      if (c > 0) @(negedge clk);
      stall_mem  = (smode == 0) ? ($urandom_range(0, 3) == 0) : (wb_n == 2 && stall_left > 0);
      mem_rvalid = (rq.size() > 0) && (rq[0] <= c);
      #1;
      if (smode == 1 && stall_mem) stall_left--;
      if (err) saw_err = 1;
      if (wr_mem) wb_cyc++;
      if (wr_mem && !stall_mem) begin
        chk("wb_mem_word", mem_word, wb_n);
        chk("wb_word_sel", {word_sel_src, word_sel}, {1'b1, WSEL_W'(wb_n)});
        chk("wb_tag_sel", tag_sel, 1);
        chk("wb_way_en", way_en, 1 << vic);
        wb_n++;
      end
      if (rd_mem && !stall_mem) begin
        chk("fill_mem_word", mem_word, iss_n);
        chk("fill_tag_sel", tag_sel, 0);
        ret = (lmode == 1) ? c + 2 : c + int'($urandom_range(1, 4));
        if (rq.size() > 0 && ret <= rq[$]) ret = rq[$] + 1;
        rq.push_back(ret);
        iss_n++;
      end
      if (mem_rvalid) begin
        chk("fill_wr_ctl", {wr_cache, comp, valid_in, data_in_sel, word_sel_src}, 5'b10111);
        chk("fill_word_sel", word_sel, fill_n);
        chk("fill_way_en", way_en, 1 << vic);
        void'(rq.pop_front());
        fill_n++;
        last_fill = c;
        if (!switched) begin
          m_valid[vic] = 1;
          m_dirty[vic] = 0;
          m_tag[vic]   = tag;
          switched     = 1;
        end
      end
      if (comp) begin
        ncomp++;
        chk("comp_wr_cache", wr_cache, is_wr);
        if (ncomp == 1 && hw >= 0) chk("hit_way_en", way_en, 1 << hw);
        if (ncomp == 2) chk("retry_way_en", way_en, 1 << vic);
      end
      if (done) begin
        fin = 1;
        chk("cache_hit", cache_hit, hw >= 0);
        chk("wb_words", wb_n, exp_wb ? WORDS : 0);
        chk("rd_issues", iss_n, (hw < 0) ? WORDS : 0);
        chk("fill_writes", fill_n, (hw < 0) ? WORDS : 0);
        chk("compare_passes", ncomp, (hw < 0) ? 2 : 1);
        chk("no_err", saw_err, 0);
        if (hw >= 0) chk("hit_latency", c, 2);
        else chk("retry_timing", c, last_fill + 2);
        if (smode == 1 && exp_wb) chk("wb_len", wb_cyc, WORDS + 3);
        rd = 0;
        wr = 0;
      end
    end
    if (!fin) begin
      chk("txn_timeout", 0, 1);
      rd = 0;
      wr = 0;
    end
    if (hw < 0 && all_v) m_rr = (m_rr + 1) % WAYS;
    if (is_wr) m_dirty[(hw >= 0) ? hw : vic] = 1;
    stall_mem  = 0;
    mem_rvalid = 0;
  endtask

  task automatic err_case(input string name, input bit r, input bit w, input logic [WSEL_W:0] off);
    @(negedge clk);
    rd = r; wr = w; offset_in = off;
    #1 chk({name, "_stall"}, stall_outside, 1);
    @(negedge clk);
    rd = 0; wr = 0; offset_in = '0;
    #1 chk({name, "_err"}, err, 1);
    @(negedge clk);
    #1 chk({name, "_idle"}, idle_vec(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1; rd = 0; wr = 0; offset_in = '0; stall_mem = 0; mem_rvalid = 0;
    cur_tag = 0; m_rr = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_enable", enable, 1);
    chk("rst_outputs", idle_vec(), 0);

    // Read hit in way 1.
    m_valid[0] = 1; m_valid[1] = 1; m_tag[0] = 10; m_tag[1] = 11;
    txn(0, 11, 0, 0);
    // Read miss with way 0 invalid: fill way 0, pointer untouched.
    m_valid[0] = 0;
    txn(0, 12, 0, 0);
    // Read miss, both valid: evict way 0 (clean), pointer moves to 1.
    txn(0, 13, 0, 0);
    // Write miss, victim way 1 dirty: writeback with stall on word 2, latency-2 fill.
    m_dirty[1] = 1;
    txn(1, 14, 1, 1);
    // Pointer has wrapped to 0.
    txn(0, 15, 0, 1);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        iw = $urandom_range(0, WAYS - 1);
        m_valid[iw] = 0;
        m_dirty[iw] = 0;
      end
      txn(1'($urandom_range(0, 1)), $urandom_range(10, 15), 0, 0);
    end

    err_case("rd_and_wr", 1, 1, '0);
    err_case("odd_offset", 1, 0, 3'b011);
    txn(0, $urandom_range(10, 15), 0, 0);

    // Reset during fill abandons the transaction.
    m_valid[0] = 0; m_dirty[0] = 0;
    @(negedge clk);
    cur_tag = 20; rd = 1; wr = 0; offset_in = '0; stall_mem = 0; mem_rvalid = 0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (rd_mem) seen = 1;
      else @(negedge clk);
    end
    chk("fill_reached", seen, 1);
    rst = 1; rd = 0;
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_fill_rd_mem", rd_mem, 0);
    chk("rst_fill_idle", idle_vec(), 0);
    @(negedge clk);
    #1 chk("rst_fill_quiet", {rd_mem, wr_mem}, 0);
    m_rr = 0;
    txn(0, 20, 0, 0);
    txn(1, 21, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
